// File: rtl/spi_slave_single_cs.sv
// SPI target for one chip select; oversamples SCK/CS_n/MOSI in i_Clk and shifts bytes MSB first.
// Latency: pin edges act SYNC_STAGES+1 i_Clk cycles later; o_RX_DV follows the 8th sample edge by two cycles.
// Backpressure: none on receive; transmit uses a one-entry holding register (o_TX_Ready), empty slot sends 8'hFF.
module spi_slave_single_cs #(
  parameter int SPI_MODE         = 3,
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int SYNC_STAGES      = 2   // must be at least 2
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_L,
  input  logic                                  i_TX_DV,
  input  logic [7:0]                            i_TX_Byte,
  output logic                                  o_TX_Ready,
  output logic                                  o_TX_Underrun,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
  output logic                                  o_Frame_Done,
  input  logic                                  i_SPI_Clk,
  input  logic                                  i_SPI_CS_n,
  input  logic                                  i_SPI_MOSI,
  output logic                                  o_SPI_MISO,
  output logic                                  o_SPI_MISO_En
);

  localparam int CW   = $clog2(MAX_BYTES_PER_CS+1);
  localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA = (SPI_MODE % 2) == 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains and edge-detect history
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   cs_dly_q, cs_dly_d;

  // FSM
  state_t state_q, state_d;
  logic   frame_start, frame_end, bit_ok, miso_en;

  // Datapath state
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_wrap_q, rx_wrap_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          underrun_q, underrun_d;
  logic          miso_q, miso_d;
  logic          frame_done_q, frame_done_d;

  // Decoded edges
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       do_sample, do_shift, byte_start;
  logic [7:0] start_byte;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;

  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // Shift the raw pins through the synchronizers and keep one cycle of history for edge detection.
  // CS is cleared to 0 on reset so a frame already low at release produces no falling edge.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
    sck_dly_d   = sck_s;
    cs_dly_d    = cs_s;
  end

  // FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: frame opens on CS_n falling, closes on CS_n rising
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: frame boundaries and whether SCK edges are honoured this cycle
  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_ok      = 1'b0;
    miso_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        frame_start = cs_fall;
      end
      ST_ACTIVE: begin
        frame_end = cs_rise;
        bit_ok    = ~cs_rise;
        miso_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign do_sample = bit_ok & sample_edge;
  assign do_shift  = bit_ok & shift_edge;

  // CPHA=0 drives the first bit at CS fall, so later bytes start on the trailing edge once a byte has completed
  assign byte_start = CPHA ? (do_shift && (bit_cnt_q == 3'd0))
                           : (frame_start || (do_shift && (bit_cnt_q == 3'd0) && (rx_count_q != '0)));

  // Receive shifting, byte delivery, MISO shifting and the transmit holding register
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_wrap_d    = 1'b0;
    rx_byte_d    = rx_byte_q;
    rx_dv_d      = 1'b0;
    rx_count_d   = rx_count_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    underrun_d   = 1'b0;
    miso_d       = miso_q;
    frame_done_d = frame_end;
    start_byte   = 8'hFF;

    if (frame_start) begin
      rx_count_d = '0;
      bit_cnt_d  = 3'd0;
    end

    // Partial byte is abandoned; holding register is left alone
    if (frame_end) begin
      bit_cnt_d = 3'd0;
    end

    if (do_sample) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      rx_wrap_d  = (bit_cnt_q == 3'd7);
    end

    // Deliver the byte the cycle after the bit counter wraps
    if (rx_wrap_q) begin
      rx_byte_d = rx_shift_q;
      rx_dv_d   = 1'b1;
      if (rx_count_q != {CW{1'b1}}) begin
        rx_count_d = rx_count_q + 1'b1;
      end
    end

    if (byte_start) begin
      if (hold_full_q) begin
        start_byte  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        start_byte = 8'hFF;
        underrun_d = 1'b1;
      end
      miso_d     = start_byte[7];
      tx_shift_d = {start_byte[6:0], 1'b0};
    end else if (do_shift) begin
      miso_d     = tx_shift_q[7];
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    // A load coincident with a byte start refills the slot just emptied
    if (i_TX_DV && (!hold_full_q || byte_start)) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  // Datapath and synchronizer registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sck_dly_q    <= 1'b0;
      cs_dly_q     <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_wrap_q    <= 1'b0;
      rx_byte_q    <= 8'h00;
      rx_dv_q      <= 1'b0;
      rx_count_q   <= '0;
      tx_shift_q   <= 8'h00;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      underrun_q   <= 1'b0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_dly_q    <= sck_dly_d;
      cs_dly_q     <= cs_dly_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_wrap_q    <= rx_wrap_d;
      rx_byte_q    <= rx_byte_d;
      rx_dv_q      <= rx_dv_d;
      rx_count_q   <= rx_count_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      underrun_q   <= underrun_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_TX_Ready    = ~hold_full_q;
  assign o_TX_Underrun = underrun_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_Count    = rx_count_q;
  assign o_Frame_Done  = frame_done_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en;

endmodule

// File: tb/tb_spi_slave_single_cs.sv
// Bench for spi_slave_single_cs: a behavioural SPI master drives a mode-3 and a mode-0 instance.
// Latency: master half-bit is 4 i_Clk cycles, MISO sampled at the master's sample edge.
// Backpressure: holding register loaded through i_TX_DV pulses between or before bytes.
`timescale 1ns/1ps
module tb_spi_slave_single_cs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Mode-3 instance signals
  logic       sck3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0, txdv3 = 1'b0;
  logic [7:0] txb3 = 8'h00;
  logic       tx_ready3, underrun3, rx_dv3, frame_done3, miso3, miso_en3;
  logic [7:0] rx_byte3;
  logic [1:0] rx_count3;

  // Mode-0 instance signals
  logic       sck0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0, txdv0 = 1'b0;
  logic [7:0] txb0 = 8'h00;
  logic       tx_ready0, underrun0, rx_dv0, frame_done0, miso0, miso_en0;
  logic [7:0] rx_byte0;
  logic [1:0] rx_count0;

  always #20 clk = ~clk;

  spi_slave_single_cs #(.SPI_MODE(3), .MAX_BYTES_PER_CS(2), .SYNC_STAGES(2)) u_dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_TX_DV(txdv3), .i_TX_Byte(txb3), .o_TX_Ready(tx_ready3), .o_TX_Underrun(underrun3),
    .o_RX_DV(rx_dv3), .o_RX_Byte(rx_byte3), .o_RX_Count(rx_count3), .o_Frame_Done(frame_done3),
    .i_SPI_Clk(sck3), .i_SPI_CS_n(cs3), .i_SPI_MOSI(mosi3),
    .o_SPI_MISO(miso3), .o_SPI_MISO_En(miso_en3)
  );

  spi_slave_single_cs #(.SPI_MODE(0), .MAX_BYTES_PER_CS(2), .SYNC_STAGES(2)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_TX_DV(txdv0), .i_TX_Byte(txb0), .o_TX_Ready(tx_ready0), .o_TX_Underrun(underrun0),
    .o_RX_DV(rx_dv0), .o_RX_Byte(rx_byte0), .o_RX_Count(rx_count0), .o_Frame_Done(frame_done0),
    .i_SPI_Clk(sck0), .i_SPI_CS_n(cs0), .i_SPI_MOSI(mosi0),
    .o_SPI_MISO(miso0), .o_SPI_MISO_En(miso_en0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling clock edge
  logic [7:0] rxq3[$];
  int         cntq3[$];
  logic [7:0] rxq0[$];
  int         nund3 = 0;
  int         nfd3  = 0;

  always @(negedge clk) begin
    if (rx_dv3) begin
      rxq3.push_back(rx_byte3);
      cntq3.push_back(int'(rx_count3));
    end
    if (underrun3)   nund3++;
    if (frame_done3) nfd3++;
    if (rx_dv0)      rxq0.push_back(rx_byte0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int m, input logic [7:0] b);
    if (m == 3) begin txdv3 = 1'b1; txb3 = b; end
    else        begin txdv0 = 1'b1; txb0 = b; end
    tick(1);
    txdv3 = 1'b0;
    txdv0 = 1'b0;
  endtask

  task automatic cs_low(input int m, input logic first_bit);
    if (m == 3) begin cs3 = 1'b0; mosi3 = first_bit; end
    else        begin cs0 = 1'b0; mosi0 = first_bit; end
    tick(4);
  endtask

  task automatic cs_high(input int m);
    if (m == 3) cs3 = 1'b1;
    else        cs0 = 1'b1;
    tick(8);
  endtask

  // Master side of nbits bit-times; returns the MISO bits captured at each master sample edge
  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (m == 3) begin
        sck3  = 1'b0;
        mosi3 = tx[3'(7 - i)];
        tick(4);
        rx   = {rx[6:0], miso3};
        sck3 = 1'b1;
        tick(4);
      end else begin
        rx   = {rx[6:0], miso0};
        sck0 = 1'b1;
        tick(4);
        sck0 = 1'b0;
        if (i < 7) mosi0 = tx[3'(6 - i)];
        tick(4);
      end
    end
  endtask

  initial begin
    logic [7:0] r1, r2;
    int         fd_base, un_base;

    // Reset state
    tick(3);
    check("rst_tx_ready", tx_ready3, 1);
    check("rst_rx_dv", rx_dv3, 0);
    check("rst_rx_count", rx_count3, 0);
    check("rst_miso_en", miso_en3, 0);
    check("rst_frame_done", frame_done3, 0);
    rst_n = 1'b1;
    tick(5);

    // Mode 3, two bytes, holding register supplied
    rxq3.delete(); cntq3.delete();
    fd_base = nfd3; un_base = nund3;
    load(3, 8'hA5);
    check("t1_ready_full", tx_ready3, 0);
    cs_low(3, 1'b0);
    check("t1_miso_en", miso_en3, 1);
    xfer(3, 8'hC1, 8, r1);
    check("t1_ready_freed", tx_ready3, 1);
    load(3, 8'h3C);
    check("t1_ready_reload", tx_ready3, 0);
    xfer(3, 8'hC2, 8, r2);
    cs_high(3);
    check("t1_miso_b0", r1, 8'hA5);
    check("t1_miso_b1", r2, 8'h3C);
    check("t1_ndv", rxq3.size(), 2);
    check("t1_rx_b0", rxq3[0], 8'hC1);
    check("t1_cnt_b0", cntq3[0], 1);
    check("t1_rx_b1", rxq3[1], 8'hC2);
    check("t1_cnt_b1", cntq3[1], 2);
    check("t1_frame_done", nfd3 - fd_base, 1);
    check("t1_underrun", nund3 - un_base, 0);
    check("t1_miso_en_off", miso_en3, 0);

    // Mode 3, holding register never loaded
    rxq3.delete(); cntq3.delete();
    un_base = nund3;
    cs_low(3, 1'b0);
    xfer(3, 8'h5E, 8, r1);
    xfer(3, 8'h17, 8, r2);
    cs_high(3);
    check("t2_miso_b0", r1, 8'hFF);
    check("t2_miso_b1", r2, 8'hFF);
    check("t2_underrun", nund3 - un_base, 2);
    check("t2_ndv", rxq3.size(), 2);
    check("t2_rx_b0", rxq3[0], 8'h5E);
    check("t2_rx_b1", rxq3[1], 8'h17);

    // Mode 0, single byte; first bit must be on MISO before the first rising SCK
    rxq0.delete();
    load(0, 8'h81);
    cs_low(0, 1'b0);
    check("t3_miso_first", miso0, 1);
    check("t3_miso_en", miso_en0, 1);
    xfer(0, 8'h5A, 8, r1);
    cs_high(0);
    check("t3_miso_byte", r1, 8'h81);
    check("t3_ndv", rxq0.size(), 1);
    check("t3_rx_byte", rxq0[0], 8'h5A);
    check("t3_rx_count", rx_count0, 1);

    // Mode 3, CS aborted after 5 bits, then a clean byte
    rxq3.delete(); cntq3.delete();
    fd_base = nfd3;
    cs_low(3, 1'b0);
    xfer(3, 8'hF0, 5, r1);
    cs_high(3);
    check("t4_no_dv", rxq3.size(), 0);
    check("t4_frame_done", nfd3 - fd_base, 1);
    cs_low(3, 1'b0);
    xfer(3, 8'h0F, 8, r1);
    cs_high(3);
    check("t4_ndv", rxq3.size(), 1);
    check("t4_rx_byte", rxq3[0], 8'h0F);
    check("t4_rx_cnt", cntq3[0], 1);

    // Mode 3, asynchronous reset mid-byte
    cs_low(3, 1'b0);
    xfer(3, 8'hAA, 3, r1);
    check("t5_pre_miso_en", miso_en3, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_ready", tx_ready3, 1);
    check("t5_async_rx_byte", rx_byte3, 0);
    check("t5_async_rx_count", rx_count3, 0);
    check("t5_async_miso", miso3, 0);
    check("t5_async_miso_en", miso_en3, 0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("t5_ignore_frame", miso_en3, 0);
    fd_base = nfd3;
    cs_high(3);
    check("t5_no_frame_done", nfd3 - fd_base, 0);
    rxq3.delete(); cntq3.delete();
    cs_low(3, 1'b0);
    xfer(3, 8'h99, 8, r1);
    cs_high(3);
    check("t5_ndv", rxq3.size(), 1);
    check("t5_rx_byte", rxq3[0], 8'h99);
    check("t5_rx_cnt", cntq3[0], 1);

    // Back-to-back loads while idle: second one dropped
    txdv3 = 1'b1; txb3 = 8'h11;
    tick(1);
    txb3 = 8'h22;
    tick(1);
    txdv3 = 1'b0;
    tick(1);
    check("t6_ready_full", tx_ready3, 0);
    cs_low(3, 1'b0);
    xfer(3, 8'h3A, 8, r1);
    cs_high(3);
    check("t6_miso_byte", r1, 8'h11);
    check("t6_ready_after", tx_ready3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_single_cs.md
Name: spi_slave_single_cs

Overview:
- SPI target (slave) for one external chip select. It is the opposite end of the SPI master with single CS.
- Runs entirely in the i_Clk domain. SCK, CS_n and MOSI are oversampled through synchronizers, and their edges are detected in i_Clk.
- Delivers received bytes with a one-cycle data-valid pulse. Returns bytes on MISO from a one-entry transmit holding register that the host core loads.

Parameters:
- SPI_MODE, 3, SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- MAX_BYTES_PER_CS, 2, maximum bytes counted per CS frame. Sets o_RX_Count width to $clog2(MAX_BYTES_PER_CS+1).
- SYNC_STAGES, 2, number of synchronizer flops on i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI (minimum 2).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_TX_DV  in  1  single-cycle pulse; loads i_TX_Byte into the holding register.
- i_TX_Byte  in  8  byte to return on MISO.
- o_TX_Ready  out  1  holding register is empty.
- o_TX_Underrun  out  1  one-cycle pulse: a byte started with the holding register empty.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte is valid.
- o_RX_Byte  out  8  last complete received byte, MSB first.
- o_RX_Count  out  $clog2(MAX_BYTES_PER_CS+1)  bytes received in the current frame.
- o_Frame_Done  out  1  one-cycle pulse on synchronized CS_n rising.
- i_SPI_Clk  in  1  SCK from the master.
- i_SPI_CS_n  in  1  chip select, active low.
- i_SPI_MOSI  in  1  master data in.
- o_SPI_MISO  out  1  target data out.
- o_SPI_MISO_En  out  1  tristate enable for MISO: 1 while CS is active.

Behaviour:
- Reset values (async on i_Rst_L=0): all outputs 0 except o_TX_Ready=1. bit_cnt=0, shift registers 0, holding register empty, state IDLE.
- Synchronizers: SYNC_STAGES flops, then one edge-detect flop. Edges act SYNC_STAGES+1 i_Clk cycles after the pin edge.
- Timing constraint: the master half-bit period must be at least 4 i_Clk cycles.
- Edge definitions:
  - Leading edge: rising when CPOL=0, falling when CPOL=1. Trailing edge is the opposite.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- States:
  - IDLE: CS_n high. SCK edges are ignored. o_SPI_MISO_En=0.
  - On synchronized CS_n falling: go to ACTIVE, o_RX_Count<=0, bit_cnt<=0, o_SPI_MISO_En<=1.
  - ACTIVE: on synchronized CS_n rising, go to IDLE, o_SPI_MISO_En<=0, pulse o_Frame_Done.
- Receive:
  - Each sample edge: rx_shift<={rx_shift[6:0], MOSI}, bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
  - When bit_cnt wraps to 0, one cycle later: o_RX_Byte<=assembled byte, o_RX_DV=1, o_RX_Count increments, saturating at 2^width-1.
- Byte-start event:
  - CPHA=0: CS_n falling, or a shift edge with bit_cnt==0 after at least one byte in the frame.
  - CPHA=1: any shift edge with bit_cnt==0.
- At a byte-start event:
  - If the holding register is full: b=holding, holding becomes empty, o_TX_Ready=1.
  - If it is empty: b=8'hFF and o_TX_Underrun pulses.
  - o_SPI_MISO<=b[7], tx_shift<=b<<1.
- Other shift edges in ACTIVE: o_SPI_MISO<=tx_shift[7], tx_shift<=tx_shift<<1.
- Holding register:
  - i_TX_DV with o_TX_Ready=1 loads the byte; o_TX_Ready drops the next cycle.
  - i_TX_DV with o_TX_Ready=0 is ignored.
  - i_TX_DV in the same cycle as a byte-start event: the byte-start consumes the old contents (or takes the underrun path), and the new byte is stored for the next byte.
- CS rising mid-byte: partial byte discarded, no o_RX_DV, bit_cnt<=0. Holding register contents are kept.
- SCK edges coincident with the CS_n rising cycle are ignored.
- Reset mid-frame: everything returns to reset values immediately. A frame already in progress is ignored until CS_n is seen high and then falls again.

Test Plan:
- Mode 3, master CLKS_PER_HALF_BIT=4, i_Clk 25 MHz, 2 bytes per CS. Holding register preloaded 0xA5, then 0x3C after o_TX_Ready rises. Master sends 0xC1, 0xC2 -> o_RX_DV pulses twice with 0xC1, then 0xC2. o_RX_Count goes 1, 2. Master receives 0xA5, 0x3C. One o_Frame_Done pulse.
- Same as above with the holding register never loaded -> master receives 0xFF, 0xFF. o_TX_Underrun pulses twice. RX bytes still correct.
- Mode 0, single byte 0x5A, holding register 0x81 -> o_RX_Byte=0x5A. MISO is 1 before the first rising SCK. Master receives 0x81.
- CS_n deasserted after 5 SCK cycles of byte 0xF0 -> no o_RX_DV, o_Frame_Done pulses. The next frame sending 0x0F gives o_RX_Byte=0x0F with o_RX_Count=1.
- i_Rst_L low for 3 cycles mid-byte -> all outputs reach reset values asynchronously. A new frame after release receives 0x99 correctly.
- i_TX_DV pulsed twice back-to-back with 0x11, 0x22 while idle -> holding register keeps 0x11 and 0x22 is dropped. Master receives 0x11.
